bus_mem_responder: RTL and testbench
====================================

# bus_mem_responder

Bus responder that serves the memory-side end of the request/response bus driven by the dcache. It accepts line read and line write requests on the bus_req channel, holds an internal word-addressed memory array, and returns read bursts on the bus_resp channel with a fixed access latency and per-beat acknowledge. It sits at the top level opposite the data cache and is the memory model every pipeline and cache test runs against.

## Interface
- BUS_DATA_WIDTH, 64, width of request and response beats
- BUS_TAG_WIDTH, 13, tag width; bit [12] = write(1)/read(0), bits [11:0] = requester ID, echoed on responses
- BEATS, 8, beats per line (power of two, 2..16)
- LATENCY, 4, cycles from reqack to first response beat (>=1)
- MEM_WORDS, 4096, 64-bit words in the array (power of two)
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; low forces all state and outputs to reset values
- bus_reqcyc  in  1  request beat valid
- bus_req  in  BUS_DATA_WIDTH  beat 0 = byte address; write beats 1..BEATS = data
- bus_reqtag  in  BUS_TAG_WIDTH  request tag, sampled with beat 0 only
- bus_reqack  out  1  one-cycle acknowledge of a sampled request beat
- bus_respcyc  out  1  response beat valid
- bus_resp  out  BUS_DATA_WIDTH  read data beat
- bus_resptag  out  BUS_TAG_WIDTH  tag of the request being answered
- bus_respack  in  1  requester accepted current response beat

## Operation
- States: IDLE, RD_WAIT, RD_BURST, WR_DATA.
- Sampling rule: a request beat is sampled in a cycle with bus_reqcyc=1 and bus_reqack=0; bus_reqack=1 in the following cycle only. Never samples while bus_reqack=1 (requester's held beat not double-counted). Min 2 cycles/request beat.
- IDLE: on sample, latch tag and line base = address with low log2(BEATS)+3 bits cleared; word index = base[3 +: log2(MEM_WORDS)]. Tag[12]=0 -> RD_WAIT, latency counter = LATENCY. Tag[12]=1 -> WR_DATA, beat counter = 0.
- RD_WAIT: counter decrements each cycle; reqcyc ignored; at 1 -> RD_BURST.
- RD_BURST: present word[index+k] on bus_resp, bus_respcyc=1, bus_resptag=latched tag; hold until bus_respack=1 sampled; next cycle present beat k+1. After respack on beat BEATS-1 -> IDLE, respcyc=0 next cycle.
- WR_DATA: each sampled beat writes word[index+k], k++; after beat BEATS-1 -> IDLE. Writes posted: no response beat.
- Index arithmetic modulo MEM_WORDS (line wraps at end of array). Low address bits below line size ignored; bursts always line-aligned, beat order ascending.
- bus_reqcyc while not IDLE (and not in WR_DATA sampling) is not acked; requester waits. New request accepted no earlier than the cycle after return to IDLE.
- Reset: state IDLE, bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0, counters 0. Array contents not cleared. Reset mid-burst abandons the burst; no partial beats afterward.

## Timing
- Read: beat 0 sampled cycle T -> reqack T+1 -> first respcyc T+1+LATENCY. With respack tied high, beats at consecutive cycles; last beat at T+LATENCY+BEATS; idle and able to sample at T+LATENCY+BEATS+1.
- Write: address T, data beat k sampled T+2+2k, write committed same edge; IDLE after edge of last data sample.
- Read-after-write to same line returns new data (write committed before IDLE).
- All outputs registered; no combinational path input->output.

## Configuration
- MEMRESP_BOUNDS_CHECK_EN defined: line base index >= MEM_WORDS (address bits above array range nonzero) -> read returns 64'hDEAD_BEEF_DEAD_BEEF every beat, write beats acked and discarded. Handshake timing unchanged.
- Undefined: upper address bits ignored, access wraps modulo MEM_WORDS.

## Test plan
- Write line addr 0x1000 data 0x11..0x88, tag 13'h1005, then read 0x1000 tag 13'h0005, respack high -> reqack T+1, beats 0x11..0x88 at T+5..T+12, resptag 13'h0005.
- Read 0x1038 (mid-line) -> same 8 beats as 0x1000, ascending order.
- Read with respack toggling 1-of-3 cycles -> each beat held stable until acked, no skipped/repeated beats.
- reqcyc asserted during RD_BURST -> no reqack until cycle after final respack; then accepted.
- reset low at beat 3 of read -> next cycle respcyc=0, reqack=0; fresh read afterwards returns full correct line.
- Address 0x8000 (MEM_WORDS=4096): without macro returns line at 0x0000; with MEMRESP_BOUNDS_CHECK_EN returns 8x DEAD_BEEF_DEAD_BEEF and prior write to 0x8000 leaves 0x0000 unchanged.

Source files
------------

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the dcache line bus: posted line writes, fixed-latency read bursts.
// Optional MEMRESP_BOUNDS_CHECK_EN: out-of-range lines read as DEAD_BEEF and drop writes.
module bus_mem_responder #(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned BUS_TAG_WIDTH  = 13,
   parameter int unsigned BEATS          = 8,
   parameter int unsigned LATENCY        = 4,
   parameter int unsigned MEM_WORDS      = 4096
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bus_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] bus_req,
   input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
   output logic                      bus_reqack,
   output logic                      bus_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] bus_resp,
   output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
   input  logic                      bus_respack
);

   localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
   localparam int unsigned BEAT_W = $clog2(BEATS);
   localparam int unsigned LAT_W  = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {StIdle, StRdWait, StRdBurst, StWrData} state_e;

   state_e                    state_q, state_d;
   logic [LAT_W-1:0]          lat_cnt_q, lat_cnt_d;
   logic [BEAT_W-1:0]         beat_q, beat_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
   logic                      reqack_q, reqack_d;
   logic                      respcyc_q, respcyc_d;
   logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
   logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;

   logic [BUS_DATA_WIDTH-1:0] mem_q [MEM_WORDS];
   logic                      sample;
   logic                      mem_we;
   logic [IDX_W-1:0]          mem_waddr;
   logic [IDX_W-1:0]          next_idx;
   logic [BUS_DATA_WIDTH-1:0] word_first;
   logic [BUS_DATA_WIDTH-1:0] word_next;

   // A beat is only taken when the previous one has been acked, so a held beat counts once.
   assign sample = bus_reqcyc && !reqack_q && ((state_q == StIdle) || (state_q == StWrData));

   assign next_idx  = idx_q + IDX_W'(beat_q) + IDX_W'(1);
   assign mem_waddr = idx_q + IDX_W'(beat_q);

`ifdef MEMRESP_BOUNDS_CHECK_EN
   localparam logic [BUS_DATA_WIDTH-1:0] Poison = BUS_DATA_WIDTH'(64'hDEAD_BEEF_DEAD_BEEF);

   logic oob_q, oob_d;

   assign word_first = oob_q ? Poison : mem_q[idx_q];
   assign word_next  = oob_q ? Poison : mem_q[next_idx];
   assign mem_we     = (state_q == StWrData) && sample && !oob_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         oob_q <= 1'b0;
      end else begin
         oob_q <= oob_d;
      end
   end
`else
   assign word_first = mem_q[idx_q];
   assign word_next  = mem_q[next_idx];
   assign mem_we     = (state_q == StWrData) && sample;
`endif

   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      beat_d    = beat_q;
      idx_d     = idx_q;
      tag_d     = tag_q;
      reqack_d  = sample;
      respcyc_d = respcyc_q;
      resp_d    = resp_q;
      resptag_d = resptag_q;
`ifdef MEMRESP_BOUNDS_CHECK_EN
      oob_d     = oob_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (sample) begin
               tag_d  = bus_reqtag;
               // Line-align: drop the beat-select bits of the word index.
               idx_d  = bus_req[3 +: IDX_W] & ~IDX_W'(BEATS - 1);
               beat_d = '0;
`ifdef MEMRESP_BOUNDS_CHECK_EN
               oob_d  = |(bus_req >> (3 + IDX_W));
`endif
               if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
                  state_d = StWrData;
               end else begin
                  state_d   = StRdWait;
                  lat_cnt_d = LAT_W'(LATENCY);
               end
            end
         end

         StRdWait: begin
            lat_cnt_d = lat_cnt_q - LAT_W'(1);
            if (lat_cnt_q == LAT_W'(1)) begin
               state_d   = StRdBurst;
               lat_cnt_d = '0;
               beat_d    = '0;
               respcyc_d = 1'b1;
               resp_d    = word_first;
               resptag_d = tag_q;
            end
         end

         StRdBurst: begin
            if (bus_respack) begin
               if (beat_q == BEAT_W'(BEATS - 1)) begin
                  state_d   = StIdle;
                  beat_d    = '0;
                  respcyc_d = 1'b0;
                  resp_d    = '0;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
                  resp_d = word_next;
               end
            end
         end

         StWrData: begin
            if (sample) begin
               if (beat_q == BEAT_W'(BEATS - 1)) begin
                  state_d = StIdle;
                  beat_d  = '0;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         lat_cnt_q <= '0;
         beat_q    <= '0;
         idx_q     <= '0;
         tag_q     <= '0;
         reqack_q  <= 1'b0;
         respcyc_q <= 1'b0;
         resp_q    <= '0;
         resptag_q <= '0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         beat_q    <= beat_d;
         idx_q     <= idx_d;
         tag_q     <= tag_d;
         reqack_q  <= reqack_d;
         respcyc_q <= respcyc_d;
         resp_q    <= resp_d;
         resptag_q <= resptag_d;
      end
   end

   // Array contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= bus_req;
      end
   end

   assign bus_reqack  = reqack_q;
   assign bus_respcyc = respcyc_q;
   assign bus_resp    = resp_q;
   assign bus_resptag = resptag_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: write/read lines, stalls, blocked requests, reset, wrap.
module tb_bus_mem_responder;

   localparam int LATENCY = 4;

   logic        clk;
   logic        reset;
   logic        bus_reqcyc;
   logic [63:0] bus_req;
   logic [12:0] bus_reqtag;
   logic        bus_reqack;
   logic        bus_respcyc;
   logic [63:0] bus_resp;
   logic [12:0] bus_resptag;
   logic        bus_respack;

   int checks   = 0;
   int failures = 0;

   logic [63:0] wr_line  [8];
   logic [63:0] exp_line [8];
   logic [63:0] line_a   [8];
   logic [63:0] line_b   [8];
   logic [63:0] line_c   [8];
   logic [63:0] line_bad [8];

   bus_mem_responder #(
      .BUS_DATA_WIDTH(64),
      .BUS_TAG_WIDTH (13),
      .BEATS         (8),
      .LATENCY       (LATENCY),
      .MEM_WORDS     (4096)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .bus_reqcyc (bus_reqcyc),
      .bus_req    (bus_req),
      .bus_reqtag (bus_reqtag),
      .bus_reqack (bus_reqack),
      .bus_respcyc(bus_respcyc),
      .bus_resp   (bus_resp),
      .bus_resptag(bus_resptag),
      .bus_respack(bus_respack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
      end
   endtask

   // Address beat, then eight data beats, each changed right after its ack.
   task automatic write_line(input logic [63:0] addr, input logic [12:0] tag, input string nm);
      bus_reqcyc = 1'b1;
      bus_req    = addr;
      bus_reqtag = tag;
      step();
      chk({nm, "_addr_ack"}, bus_reqack, 1);
      for (int k = 0; k < 8; k++) begin
         bus_req = wr_line[k];
         step();
         chk({nm, "_ack_lo"}, bus_reqack, 0);
         step();
         chk({nm, "_data_ack"}, bus_reqack, 1);
      end
      bus_reqcyc = 1'b0;
      step();
   endtask

   task automatic issue_read(input logic [63:0] addr, input logic [12:0] tag, input string nm);
      bus_reqcyc = 1'b1;
      bus_req    = addr;
      bus_reqtag = tag;
      step();
      chk({nm, "_reqack"}, bus_reqack, 1);
      chk({nm, "_nocyc"}, bus_respcyc, 0);
      bus_reqcyc = 1'b0;
   endtask

   // Entered in the reqack cycle; respack held high, exact cycle timing checked.
   task automatic collect_burst(input logic [12:0] tag, input string nm);
      bus_respack = 1'b1;
      for (int i = 0; i < LATENCY - 1; i++) begin
         step();
         chk({nm, "_wait_cyc"}, bus_respcyc, 0);
         chk({nm, "_wait_ack"}, bus_reqack, 0);
      end
      for (int k = 0; k < 8; k++) begin
         step();
         chk({nm, "_beat_cyc"}, bus_respcyc, 1);
         chk({nm, "_beat_data"}, bus_resp, exp_line[k]);
         chk({nm, "_beat_tag"}, bus_resptag, tag);
         chk({nm, "_beat_ack"}, bus_reqack, 0);
      end
      step();
      chk({nm, "_end_cyc"}, bus_respcyc, 0);
      chk({nm, "_end_ack"}, bus_reqack, 0);
   endtask

   // respack high one cycle in three; each beat must hold until taken.
   task automatic collect_stall(input logic [12:0] tag, input string nm);
      int n = 0;
      int cyc = 0;
      logic        hold = 1'b0;
      logic [63:0] prev = '0;
      while (n < 8 && cyc < 200) begin
         bus_respack = (cyc % 3 == 2);
         if (bus_respcyc) begin
            if (hold) chk({nm, "_stable"}, bus_resp, prev);
            if (bus_respack) begin
               chk({nm, "_data"}, bus_resp, exp_line[n]);
               chk({nm, "_tag"}, bus_resptag, tag);
               n++;
               hold = 1'b0;
            end else begin
               hold = 1'b1;
               prev = bus_resp;
            end
         end
         cyc++;
         step();
      end
      chk({nm, "_beats"}, 64'(n), 64'd8);
      bus_respack = 1'b0;
      chk({nm, "_end_cyc"}, bus_respcyc, 0);
   endtask

   initial begin
      line_a   = '{64'h11, 64'h22, 64'h33, 64'h44, 64'h55, 64'h66, 64'h77, 64'h88};
      line_b   = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'hA4, 64'hA5, 64'hA6, 64'hA7};
      line_c   = '{64'hC0, 64'hC1, 64'hC2, 64'hC3, 64'hC4, 64'hC5, 64'hC6, 64'hC7};
      for (int k = 0; k < 8; k++) line_bad[k] = 64'hDEAD_BEEF_DEAD_BEEF;

      reset       = 1'b0;
      bus_reqcyc  = 1'b0;
      bus_req     = '0;
      bus_reqtag  = '0;
      bus_respack = 1'b0;
      step();
      step();
      chk("rst_reqack", bus_reqack, 0);
      chk("rst_respcyc", bus_respcyc, 0);
      chk("rst_resp", bus_resp, 0);
      chk("rst_resptag", bus_resptag, 0);
      reset = 1'b1;
      step();

      wr_line = line_b;
      write_line(64'h0000, 13'h1001, "wr0000");
      wr_line = line_a;
      write_line(64'h1000, 13'h1005, "wr1000");

      exp_line = line_a;
      issue_read(64'h1000, 13'h0005, "rd1000");
      collect_burst(13'h0005, "rd1000");

      issue_read(64'h1038, 13'h0007, "rd1038");
      collect_burst(13'h0007, "rd1038");

      issue_read(64'h1000, 13'h0009, "stall");
      collect_stall(13'h0009, "stall");

      // Second request held through the whole first burst.
      exp_line   = line_b;
      issue_read(64'h0000, 13'h000A, "blk1");
      bus_reqcyc = 1'b1;
      bus_req    = 64'h1000;
      bus_reqtag = 13'h000B;
      collect_burst(13'h000A, "blk1");
      step();
      chk("blk2_reqack", bus_reqack, 1);
      bus_reqcyc = 1'b0;
      exp_line   = line_a;
      collect_burst(13'h000B, "blk2");

      // Reset while beat 3 is on the bus.
      issue_read(64'h1000, 13'h000C, "rstmid");
      bus_respack = 1'b1;
      for (int i = 0; i < LATENCY - 1; i++) step();
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rstmid_beat", bus_resp, line_a[k]);
      end
      reset = 1'b0;
      step();
      chk("rstmid_respcyc", bus_respcyc, 0);
      chk("rstmid_reqack", bus_reqack, 0);
      chk("rstmid_resp", bus_resp, 0);
      reset = 1'b1;
      step();
      chk("rstmid_idle", bus_respcyc, 0);
      exp_line = line_b;
      issue_read(64'h0000, 13'h000D, "postrst");
      collect_burst(13'h000D, "postrst");

`ifdef MEMRESP_BOUNDS_CHECK_EN
      exp_line = line_bad;
`else
      exp_line = line_b;
`endif
      issue_read(64'h8000, 13'h000E, "rd8000");
      collect_burst(13'h000E, "rd8000");

      wr_line = line_c;
      write_line(64'h8000, 13'h100F, "wr8000");
`ifdef MEMRESP_BOUNDS_CHECK_EN
      exp_line = line_b;
`else
      exp_line = line_c;
`endif
      issue_read(64'h0000, 13'h0010, "rd0000");
      collect_burst(13'h0010, "rd0000");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
